pixel_readback: RTL and testbench
=================================

# pixel_readback

Framebuffer capture-and-readback engine for the 160×120, 3-bit-colour plot interface. It sits on the sink side of the plot bus, in parallel with the VGA adapter, and records every plotted pixel into a private shadow framebuffer. On request it streams the whole frame back out in raster order over a valid/ready interface, so on-chip logic can check drawing results or dump them.

## Interface
- `FB_W`, 160: screen width in pixels.
- `FB_H`, 120: screen height in pixels.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `vga_x` input 8: plot x coordinate.
- `vga_y` input 7: plot y coordinate.
- `vga_colour` input 3: plot colour.
- `vga_plot` input 1: write strobe; one pixel captured per cycle it is high.
- `start` input 1: level request to begin a readback scan.
- `done` output 1: scan complete; held high until the next accepted `start`.
- `out_x` output 8: streamed pixel x.
- `out_y` output 7: streamed pixel y.
- `out_colour` output 3: streamed pixel colour.
- `out_valid` output 1: streamed pixel present.
- `out_ready` input 1: consumer accepts pixel.
- `pix_count` output 15: pixels accepted by the consumer in the current or last scan.
- `mismatch_count` output 15: exists only with the check macro defined (see Configuration).

## Operation
- Capture: when `vga_plot`=1, `vga_x`<160 and `vga_y`<120, write `vga_colour` to address `vga_y*160+vga_x`.
  - Compute the address as `(y<<7)+(y<<5)+x`, 15 bits.
  - Ignore out-of-range coordinates silently.
  - Capture runs in every state, including during a scan.
- Memory contents are not reset. They are undefined until written.
- FSM states: IDLE, RD, PRES, DONE.
  - IDLE: `start`=1 → RD. Clear the counters and set the scan pointer to (0,0).
  - RD: present the read address. Next cycle → PRES.
  - PRES: `out_valid`=1. On `out_valid&&out_ready`, increment `pix_count`.
    - If the pointer was at (159,119) → DONE.
    - Otherwise advance x, wrapping 159→0 with y+1, and go → RD.
  - DONE: `done`=1. `start`=1 → RD with the same clearing as in IDLE. `done` drops on the transition.
- `start` is ignored in RD and PRES.
- Read-during-write to the same address in the same cycle: the scan returns the old data.
- The scan is raster order: x inner, y outer.

## Timing
- Reset values: `out_valid`=0, `done`=0, `out_x`=0, `out_y`=0, `out_colour`=0, `pix_count`=0, `mismatch_count`=0. The FSM is in IDLE.
- A write is visible to reads starting the cycle after the `vga_plot` edge.
- RAM read latency is 1 cycle, with a registered output.
- Per pixel: 2 cycles with `out_ready` held at 1, so a full frame takes 38400 cycles from `start` to `done`.
- `out_x`, `out_y` and `out_colour` are stable while `out_valid`=1 and `out_ready`=0.
- `rst_n` low mid-scan: immediately return to IDLE and restore all outputs to reset values. The RAM keeps its contents.

## Configuration
- `PIXEL_READBACK_CHECK_EN` defined:
  - Adds output `mismatch_count`.
  - On each accepted pixel, increment it if `out_colour` != `out_x[2:0]` (the `x mod 8` fill pattern).
  - Clear it on scan start.
- Undefined: no comparator, and no `mismatch_count` port.

## Structure
- Package `pixel_pkg`:
  - `FB_W`, `FB_H`, `FB_DEPTH`=19200 and `ADDR_W`=15.
  - `colour_t` (logic [2:0]).
  - State enum `rb_state_t` {IDLE, RD, PRES, DONE}.
- Sub-module `fb_ram`: simple dual-port RAM, 19200×3, with a synchronous write port and a registered synchronous read port.
- `pixel_readback` holds the FSM, scan pointer, address arithmetic and counters.

## Test plan
- Fill pattern, no stalls: plot all 19200 pixels with colour `x%8`, pulse `start`, hold `out_ready`=1.
  - Pixels stream (0,0),(1,0)…(159,119) with colour `x%8`.
  - `done` goes high 38400 cycles after `start`.
  - `pix_count`=19200 and `mismatch_count`=0.
- Single error: as the fill-pattern test, then overwrite (5,3) with colour 7 before the scan → `mismatch_count`=1. The stream shows colour 7 at (5,3).
- Backpressure: toggle `out_ready` pseudo-randomly.
  - Outputs stay stable while stalled.
  - No pixel is lost or duplicated.
  - `pix_count`=19200.
- Out-of-range plots: plot (160,0) and (0,120) with colour 2 → the stream shows no change at (0,0), (0,1) or (159,0).
- Reset mid-scan: assert `rst_n`=0 after 1000 accepted pixels.
  - `out_valid`=0, `done`=0 and counters=0 immediately.
  - A subsequent scan returns the previously captured frame.
- Restart and ignored start:
  - `start` pulses during a scan are ignored.
  - `start` in DONE drops `done` and reruns from (0,0) with the counters cleared.

Source files
------------

// File: rtl/pixel_readback_pkg.sv
// rtl/pixel_readback_pkg.sv - shared types, geometry constants and address helper for pixel_readback
package pixel_pkg;

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_DEPTH = 19200;
  localparam int ADDR_W   = 15;

  typedef logic [2:0] colour_t;

  typedef enum logic [1:0] {IDLE, RD, PRES, DONE} rb_state_t;

  // y*160 + x using shifts only: y*128 + y*32 + x
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
    logic [ADDR_W-1:0] yy;
    yy = ADDR_W'(y);
    return (yy << 7) + (yy << 5) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/pixel_readback_if.sv
// rtl/pixel_readback_if.sv - readback pixel stream (valid/ready) between engine and consumer
interface pixel_readback_if;
  import pixel_pkg::*;

  logic [7:0] x;
  logic [6:0] y;
  colour_t    colour;
  logic       valid;
  logic       ready;

  modport master (output x, output y, output colour, output valid, input ready);
  modport slave  (input x, input y, input colour, input valid, output ready);

endinterface

// File: rtl/pixel_readback_fb_ram.sv
// rtl/pixel_readback_fb_ram.sv - 19200x3 simple dual-port shadow framebuffer, registered read port
module fb_ram
  import pixel_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  colour_t           wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output colour_t           rdata
);

  colour_t mem [FB_DEPTH];

  // Non-blocking read and write on the same edge: a colliding read returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pixel_readback.sv
// rtl/pixel_readback.sv - capture plotted pixels, stream the frame back in raster order
// Optional x-mod-8 fill checker with mismatch_count port: PIXEL_READBACK_CHECK_EN
module pixel_readback
  import pixel_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          vga_x,
  input  logic [6:0]          vga_y,
  input  colour_t             vga_colour,
  input  logic                vga_plot,
  input  logic                start,
  output logic                done,
  pixel_readback_if.master    stream,
  output logic [14:0]         pix_count
`ifdef PIXEL_READBACK_CHECK_EN
  ,
  output logic [14:0]         mismatch_count
`endif
);

  rb_state_t state, state_next;
  logic [7:0] x_ptr;
  logic [6:0] y_ptr;
  colour_t    rd_data;
  logic       scan_clear;
  logic       accept;
  logic       last_pix;
  logic       wr_en;

  assign wr_en    = vga_plot && (vga_x < 8'(FB_W)) && (vga_y < 7'(FB_H));
  assign last_pix = (x_ptr == 8'(FB_W - 1)) && (y_ptr == 7'(FB_H - 1));

  fb_ram u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (fb_addr(vga_x, vga_y)),
    .wdata (vga_colour),
    .re    (state == RD),
    .raddr (fb_addr(x_ptr, y_ptr)),
    .rdata (rd_data)
  );

  // The RAM output register is unreset, so colour is forced to zero outside PRES.
  assign stream.x      = x_ptr;
  assign stream.y      = y_ptr;
  assign stream.colour = (state == PRES) ? rd_data : '0;

  always_comb begin
    state_next   = state;
    scan_clear   = 1'b0;
    accept       = 1'b0;
    stream.valid = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RD;
          scan_clear = 1'b1;
        end
      end
      RD: state_next = PRES;
      PRES: begin
        stream.valid = 1'b1;
        if (stream.ready) begin
          accept     = 1'b1;
          state_next = last_pix ? DONE : RD;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_next = RD;
          scan_clear = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x_ptr     <= '0;
      y_ptr     <= '0;
      pix_count <= '0;
    end else begin
      state <= state_next;
      if (scan_clear) begin
        x_ptr     <= '0;
        y_ptr     <= '0;
        pix_count <= '0;
      end else if (accept) begin
        pix_count <= pix_count + 15'd1;
        if (!last_pix) begin
          if (x_ptr == 8'(FB_W - 1)) begin
            x_ptr <= '0;
            y_ptr <= y_ptr + 7'd1;
          end else begin
            x_ptr <= x_ptr + 8'd1;
          end
        end
      end
    end
  end

`ifdef PIXEL_READBACK_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_count <= '0;
    end else if (scan_clear) begin
      mismatch_count <= '0;
    end else if (accept && (rd_data != x_ptr[2:0])) begin
      mismatch_count <= mismatch_count + 15'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_readback.sv
// tb/tb_pixel_readback.sv - randomized self-checking bench for pixel_readback against a frame model
module tb_pixel_readback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        start;
  logic        done;
  logic [14:0] pix_count;
`ifdef PIXEL_READBACK_CHECK_EN
  logic [14:0] mismatch_count;
`endif

  pixel_readback_if bus ();

  pixel_readback dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .vga_x          (vga_x),
    .vga_y          (vga_y),
    .vga_colour     (vga_colour),
    .vga_plot       (vga_plot),
    .start          (start),
    .done           (done),
    .stream         (bus.master),
    .pix_count      (pix_count)
`ifdef PIXEL_READBACK_CHECK_EN
    ,
    .mismatch_count (mismatch_count)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int model [19200];
  int idx;

  task automatic plot(input int x, input int y, input int c);
    @(negedge clk);
    vga_x      = 8'(x);
    vga_y      = 7'(y);
    vga_colour = 3'(c);
    vga_plot   = 1'b1;
    if (x < 160 && y < 120) model[y * 160 + x] = c;
  endtask

  task automatic plot_end();
    @(negedge clk);
    vga_plot = 1'b0;
  endtask

  task automatic start_scan();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx = 0;
  endtask

  function automatic int model_mismatches(input int n);
    int m = 0;
    for (int i = 0; i < n; i++) if (model[i] != (i % 160) % 8) m++;
    return m;
  endfunction

  // Consumes n pixels; returns at the negedge where the n-th acceptance is decided.
  task automatic scan(input int n, input int ready_pct, input bit poke_start, output int cyc);
    int acc = 0;
    bit pend = 0;
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
    cyc = 0;
    while (acc < n && cyc < n * 20 + 100) begin
      @(negedge clk);
      cyc++;
      if (poke_start) start = ($urandom_range(0, 9) == 0);
      bus.ready = ($urandom_range(0, 99) < ready_pct);
      if (pend) begin
        tests++;
        if (bus.valid !== 1'b1 || bus.x !== px || bus.y !== py || bus.colour !== pc) begin
          fails++;
          $display("FAIL stall_hold: got v%0b (%0d,%0d,c%0d) required v1 (%0d,%0d,c%0d)",
                   bus.valid, bus.x, bus.y, bus.colour, px, py, pc);
        end
      end
      if (bus.valid === 1'b1 && bus.ready) begin
        tests++;
        if (idx >= 19200 || bus.x !== 8'(idx % 160) || bus.y !== 7'(idx / 160) ||
            bus.colour !== 3'(model[idx % 19200])) begin
          fails++;
          $display("FAIL pixel_%0d: got (%0d,%0d,c%0d) required (%0d,%0d,c%0d)", idx,
                   bus.x, bus.y, bus.colour, idx % 160, idx / 160, model[idx % 19200]);
        end
        idx++;
        acc++;
      end
      pend = (bus.valid === 1'b1) && !bus.ready;
      px = bus.x;
      py = bus.y;
      pc = bus.colour;
    end
    start = 1'b0;
    tests++;
    if (acc != n) begin
      fails++;
      $display("FAIL scan_timeout: got %0d pixels required %0d", acc, n);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    tests++;
    if (bus.valid !== 1'b0 || done !== 1'b0 || bus.x !== 8'd0 || bus.y !== 7'd0 ||
        bus.colour !== 3'd0 || pix_count !== 15'd0) begin
      fails++;
      $display("FAIL %s: got v%0b d%0b x%0d y%0d c%0d cnt%0d required all zero", tag,
               bus.valid, done, bus.x, bus.y, bus.colour, pix_count);
    end
`ifdef PIXEL_READBACK_CHECK_EN
    tests++;
    if (mismatch_count !== 15'd0) begin
      fails++;
      $display("FAIL %s_mismatch: got %0d required 0", tag, mismatch_count);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("idle_after_reset");
  endtask

  task automatic test_fill_single_error_oor();
    int cyc;
    int done_cyc = -1;
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++) plot(x, y, x % 8);
    plot(160, 0, 2);
    plot(0, 120, 2);
    plot(5, 3, 7);
    plot_end();
    start_scan();
    scan(19200, 100, 1'b0, cyc);
    for (int i = 0; i < 10 && done_cyc < 0; i++) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) done_cyc = cyc;
    end
    tests++;
    if (done_cyc != 38400) begin
      fails++;
      $display("FAIL done_latency: got %0d cycles required 38400", done_cyc);
    end
    tests++;
    if (pix_count !== 15'd19200) begin
      fails++;
      $display("FAIL full_pix_count: got %0d required 19200", pix_count);
    end
`ifdef PIXEL_READBACK_CHECK_EN
    tests++;
    if (int'(mismatch_count) != model_mismatches(19200) || mismatch_count !== 15'd1) begin
      fails++;
      $display("FAIL single_error_mismatch: got %0d required 1", mismatch_count);
    end
`endif
  endtask

  task automatic test_restart_backpressure_reset();
    int cyc;
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL done_held: got %0b required 1", done);
    end
    start_scan();
    tests++;
    if (done !== 1'b0 || pix_count !== 15'd0) begin
      fails++;
      $display("FAIL restart_clear: got done %0b cnt %0d required 0 0", done, pix_count);
    end
    scan(1000, 60, 1'b1, cyc);
    @(posedge clk);
    #1;
    tests++;
    if (pix_count !== 15'd1000) begin
      fails++;
      $display("FAIL backpressure_count: got %0d required 1000", pix_count);
    end
`ifdef PIXEL_READBACK_CHECK_EN
    tests++;
    if (int'(mismatch_count) != model_mismatches(1000)) begin
      fails++;
      $display("FAIL partial_mismatch: got %0d required %0d", mismatch_count, model_mismatches(1000));
    end
`endif
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_mid_scan");
    @(negedge clk);
    rst_n = 1'b1;
    bus.ready = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("idle_after_mid_reset");
  endtask

  task automatic test_rescan_preserved();
    int cyc;
    for (int i = 0; i < 24; i++)
      plot($urandom_range(0, 170), $urandom_range(0, 3), $urandom_range(0, 7));
    plot_end();
    start_scan();
    scan(600, 100, 1'b0, cyc);
    @(posedge clk);
    #1;
    tests++;
    if (pix_count !== 15'd600) begin
      fails++;
      $display("FAIL rescan_count: got %0d required 600", pix_count);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    start      = 1'b0;
    bus.ready  = 1'b1;
    test_reset();
    test_fill_single_error_oor();
    test_restart_backpressure_reset();
    test_rescan_preserved();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
